// File: rtl/wb_openram_pkg.sv
// Shared types and constants for the two-port Wishbone to OpenRAM arbiter.
package wb_openram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_READ = 1'b1;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Combinational two-requester round-robin choice: a lone requester wins,
// on a tie the requester that was not served last wins.
module wb_rr_arbiter2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic gnt,
    output logic valid
);

    assign valid = req_a | req_b;
    assign gnt   = (req_a & req_b) ? ~last : req_b;

endmodule

// File: rtl/wb_openram_arbiter.sv
// Shares OpenRAM port 0 between Wishbone slaves A and B using an
// IDLE -> ACCESS -> ACK sequencer with round-robin grant.
module wb_openram_arbiter
    import wb_openram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  wbs_a_stb_i,
    input  logic                  wbs_a_cyc_i,
    input  logic                  wbs_a_we_i,
    input  logic [3:0]            wbs_a_sel_i,
    input  logic [31:0]           wbs_a_dat_i,
    input  logic [ADDR_WIDTH+1:0] wbs_a_adr_i,
    output logic                  wbs_a_ack_o,
    output logic [31:0]           wbs_a_dat_o,

    input  logic                  wbs_b_stb_i,
    input  logic                  wbs_b_cyc_i,
    input  logic                  wbs_b_we_i,
    input  logic [3:0]            wbs_b_sel_i,
    input  logic [31:0]           wbs_b_dat_i,
    input  logic [ADDR_WIDTH+1:0] wbs_b_adr_i,
    output logic                  wbs_b_ack_o,
    output logic [31:0]           wbs_b_dat_o,

    output logic                  ram_clk0,
    output logic                  ram_csb0,
    output logic                  ram_web0,
    output logic [3:0]            ram_wmask0,
    output logic [ADDR_WIDTH-1:0] ram_addr0,
    output logic [31:0]           ram_din0,
    input  logic [31:0]           ram_dout0,

    output logic                  grant_b_o
);

    state_e                  state_q, state_d;
    port_e                   gnt_q, gnt_d;
    port_e                   last_q, last_d;
    logic                    csb_q, csb_d;
    logic                    web_q, web_d;
    logic [3:0]              wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             din_q, din_d;

    logic                    req_a, req_b;
    logic                    arb_gnt, arb_valid;
    logic                    sel_we;
    logic [3:0]              sel_sel;
    logic [31:0]             sel_dat;
    logic [ADDR_WIDTH+1:0]   sel_adr;
    logic                    in_ack;
    logic                    unused_adr_bits;

    assign req_a = wbs_a_stb_i & wbs_a_cyc_i;
    assign req_b = wbs_b_stb_i & wbs_b_cyc_i;

    wb_rr_arbiter2 u_arb (
        .req_a (req_a),
        .req_b (req_b),
        .last  (last_q == PORT_B),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    assign sel_we  = arb_gnt ? wbs_b_we_i  : wbs_a_we_i;
    assign sel_sel = arb_gnt ? wbs_b_sel_i : wbs_a_sel_i;
    assign sel_dat = arb_gnt ? wbs_b_dat_i : wbs_a_dat_i;
    assign sel_adr = arb_gnt ? wbs_b_adr_i : wbs_a_adr_i;

    // Byte-offset bits are irrelevant to a word-wide RAM.
    assign unused_adr_bits = ^{wbs_a_adr_i[1:0], wbs_b_adr_i[1:0]};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = ACCESS;
                    gnt_d   = port_e'(arb_gnt);
                    csb_d   = 1'b0;
                    web_d   = ~sel_we;
                    wmask_d = sel_we ? sel_sel : 4'h0;
                    addr_d  = sel_adr[ADDR_WIDTH+1:2];
                    din_d   = sel_dat;
                end
            end
            ACCESS: begin
                state_d = ACK;
                csb_d   = CSB_IDLE;
                web_d   = WEB_READ;
                wmask_d = 4'h0;
            end
            ACK: begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            gnt_q   <= PORT_B;
            last_q  <= PORT_B;
            csb_q   <= CSB_IDLE;
            web_q   <= WEB_READ;
            wmask_q <= 4'h0;
            addr_q  <= '0;
            din_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Ack depends on live cyc so an aborted cycle is never acknowledged.
    assign in_ack      = (state_q == ACK);
    assign wbs_a_ack_o = in_ack & (gnt_q == PORT_A) & wbs_a_cyc_i;
    assign wbs_b_ack_o = in_ack & (gnt_q == PORT_B) & wbs_b_cyc_i;
    assign wbs_a_dat_o = (in_ack && gnt_q == PORT_A) ? ram_dout0 : 32'h0;
    assign wbs_b_dat_o = (in_ack && gnt_q == PORT_B) ? ram_dout0 : 32'h0;

    assign ram_clk0   = wb_clk_i;
    assign ram_csb0   = csb_q;
    assign ram_web0   = web_q;
    assign ram_wmask0 = wmask_q;
    assign ram_addr0  = addr_q;
    assign ram_din0   = din_q;
    assign grant_b_o  = (gnt_q == PORT_B);

endmodule
